// File: rtl/bram_port_arbiter.sv
// Shares one 32-bit data BRAM between instruction fetch and the load/store unit.
// Round-robin arbitration, one access per grant, RV32I lane steering and load extension.
module bram_port_arbiter #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [1:0]        ls_size,
    input  logic              ls_unsigned,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ls_err,
    output logic [ADDR_W-1:0] mem_w_addr,
    output logic [DATA_W-1:0] mem_w_dat,
    output logic [3:0]        mem_w_enb,
    output logic [ADDR_W-1:0] mem_r_addr,
    output logic [3:0]        mem_r_enb,
    input  logic [DATA_W-1:0] mem_r_dat
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    typedef struct packed {
        logic       is_ls;
        logic       we;
        logic [1:0] size;
        logic       uns;
        logic       err;
        logic [1:0] lane;
    } req_t;

    state_t            state_q, state_d;
    logic              last_ls_q;
    req_t              req_q;
    logic              win_if, win_ls;
    logic              ls_misal;
    logic [3:0]        st_mask;
    logic [DATA_W-1:0] st_dat;
    logic [DATA_W-1:0] ld_shift;
    logic [DATA_W-1:0] ld_val;
    logic              unused_if_lane;

    // IF addresses are word-aligned by contract; the low bits carry no information.
    assign unused_if_lane = ^if_addr[1:0];

    // Next state and round-robin winner; arbitration only in IDLE and RESP.
    always_comb begin
        state_d = state_q;
        win_if  = 1'b0;
        win_ls  = 1'b0;
        case (state_q)
            IDLE, RESP: begin
                if (if_req && ls_req) begin
                    if (last_ls_q) win_if = 1'b1;
                    else           win_ls = 1'b1;
                end else if (if_req) begin
                    win_if = 1'b1;
                end else if (ls_req) begin
                    win_ls = 1'b1;
                end
                state_d = (win_if || win_ls) ? ACCESS : IDLE;
            end
            ACCESS:  state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    // Store lane steering and alignment check on the live LSU request.
    always_comb begin
        ls_misal = (ls_size == 2'b11) ||
                   ((ls_size == 2'b01) && ls_addr[0]) ||
                   ((ls_size == 2'b10) && (ls_addr[1:0] != 2'b00));
        case (ls_size)
            2'b00: begin
                st_mask = 4'b0001 << ls_addr[1:0];
                st_dat  = {4{ls_wdata[7:0]}};
            end
            2'b01: begin
                st_mask = ls_addr[1] ? 4'b1100 : 4'b0011;
                st_dat  = {2{ls_wdata[15:0]}};
            end
            default: begin
                st_mask = 4'b1111;
                st_dat  = ls_wdata;
            end
        endcase
    end

    // Load extract from the BRAM word using the latched lane and size.
    always_comb begin
        ld_shift = mem_r_dat >> {req_q.lane, 3'b000};
        case (req_q.size)
            2'b00:   ld_val = {{(DATA_W-8){ld_shift[7] & ~req_q.uns}}, ld_shift[7:0]};
            2'b01:   ld_val = {{(DATA_W-16){ld_shift[15] & ~req_q.uns}}, ld_shift[15:0]};
            default: ld_val = ld_shift;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_ls_q  <= 1'b0;
            req_q      <= '0;
            if_gnt     <= 1'b0;
            if_rvalid  <= 1'b0;
            if_rdata   <= '0;
            ls_gnt     <= 1'b0;
            ls_rvalid  <= 1'b0;
            ls_rdata   <= '0;
            ls_err     <= 1'b0;
            mem_w_addr <= '0;
            mem_w_dat  <= '0;
            mem_w_enb  <= '0;
            mem_r_addr <= '0;
            mem_r_enb  <= '0;
        end else begin
            state_q   <= state_d;
            if_gnt    <= win_if;
            ls_gnt    <= win_ls;
            mem_w_enb <= '0;
            mem_r_enb <= '0;
            if_rvalid <= 1'b0;
            ls_rvalid <= 1'b0;
            ls_err    <= 1'b0;

            // Grant edge: latch the request and set up the BRAM for the ACCESS cycle.
            if (win_if) begin
                last_ls_q  <= 1'b0;
                req_q      <= '{is_ls: 1'b0, we: 1'b0, size: 2'b10, uns: 1'b0,
                                err: 1'b0, lane: 2'b00};
                mem_r_addr <= {if_addr[ADDR_W-1:2], 2'b00};
                mem_r_enb  <= 4'b1111;
            end else if (win_ls) begin
                last_ls_q <= 1'b1;
                req_q     <= '{is_ls: 1'b1, we: ls_we, size: ls_size, uns: ls_unsigned,
                               err: ls_misal, lane: ls_addr[1:0]};
                if (!ls_misal) begin
                    if (ls_we) begin
                        mem_w_addr <= ls_addr;
                        mem_w_dat  <= st_dat;
                        mem_w_enb  <= st_mask;
                    end else begin
                        mem_r_addr <= {ls_addr[ADDR_W-1:2], 2'b00};
                        mem_r_enb  <= 4'b1111;
                    end
                end
            end

            // End of ACCESS: capture read data into the response registers.
            if (state_q == ACCESS) begin
                if (req_q.is_ls) begin
                    ls_rvalid <= 1'b1;
                    ls_err    <= req_q.err;
                    ls_rdata  <= (req_q.err || req_q.we) ? '0 : ld_val;
                end else begin
                    if_rvalid <= 1'b1;
                    if_rdata  <= mem_r_dat;
                end
            end
        end
    end

endmodule

// File: doc/bram_port_arbiter.md
# bram_port_arbiter

Sequences and shares the single 32-bit data BRAM between instruction fetch (IF) and the load/store unit (LSU). Arbitrates round-robin, drives the BRAM write/read port one access at a time, and performs RV32I byte-lane steering. It also handles sign/zero extension and misalignment detection. Sits between the core pipeline and the BRAM instance.

## Interface
- `ADDR_W`, 12, byte-address width (1024 words × 4 bytes).
- `DATA_W`, 32, data width; the block is defined for 32 only.

Ports:
- `clk` in 1: clock. All logic is on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `if_req` in 1: IF read request. The requester holds it until it sees `if_gnt`.
- `if_addr` in ADDR_W: IF byte address. It must be word-aligned; bits [1:0] are ignored.
- `if_gnt` out 1: one-cycle pulse; the IF request is accepted.
- `if_rvalid` out 1: one-cycle pulse; `if_rdata` is valid.
- `if_rdata` out 32: fetched word.
- `ls_req` in 1: LSU request. The requester holds it with all `ls_*` inputs stable until `ls_gnt`.
- `ls_we` in 1: 1 = store, 0 = load.
- `ls_size` in 2: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `ls_unsigned` in 1: load zero-extends when 1, sign-extends when 0.
- `ls_addr` in ADDR_W: LSU byte address.
- `ls_wdata` in 32: store data, right-justified.
- `ls_gnt` out 1: one-cycle pulse; the LSU request is accepted.
- `ls_rvalid` out 1: one-cycle pulse; completion for loads and stores.
- `ls_rdata` out 32: extended load data. It is 0 for stores and errors.
- `ls_err` out 1: valid with `ls_rvalid`; the access was misaligned or illegal.
- `mem_w_addr` out ADDR_W: BRAM write byte address.
- `mem_w_dat` out 32: BRAM write data, lane-replicated.
- `mem_w_enb` out 4: BRAM byte write mask.
- `mem_r_addr` out ADDR_W: BRAM read byte address, word-aligned ({addr[11:2],2'b00}).
- `mem_r_enb` out 4: BRAM read enable.
- `mem_r_dat` in 32: BRAM read data, combinational from `mem_r_addr`.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **Arbitration in IDLE and RESP:** the block samples `if_req`/`ls_req`.
  - One request present: it wins.
  - Both present: the requester not served last wins.
  - Last-served pointer resets to IF, so LSU wins the first conflict.
- **Winner handling:**
  - Latch the winner's id, address, size, data and we.
  - Assert that requester's gnt for exactly the next cycle.
  - Go to ACCESS.
  - With no request, IDLE stays IDLE and RESP goes to IDLE.
- **ACCESS (one cycle):** drives the BRAM from the latched request only.
  - Read: `mem_r_enb`=4'b1111, `mem_w_enb`=0.
  - Write: `mem_w_enb`=lane mask, `mem_r_enb`=0. The BRAM ignores writes while `mem_r_enb`≠0, so both are never nonzero together.
  - The block registers `mem_r_dat` at the end of ACCESS, then goes to RESP.
- **RESP (one cycle):** pulses the winner's rvalid with data, and re-arbitrates in the same cycle.
- **Outside ACCESS:** `mem_w_enb`=0 and `mem_r_enb`=0. Address and data outputs hold their last values.
- **Store lanes:**
  - byte: mask=1<<addr[1:0], data={4{wdata[7:0]}}.
  - half: mask=addr[1]?4'b1100:4'b0011, data={2{wdata[15:0]}}.
  - word: mask=4'b1111, data=wdata.
- **Load extract:** shift `mem_r_dat` right by 8·addr[1:0], keep 8/16/32 bits, then sign- or zero-extend per `ls_unsigned`.
- **Misaligned or illegal LSU request:** half with addr[0]=1, word with addr[1:0]≠0, or size 11.
  - It is still granted and still passes through ACCESS.
  - Both BRAM enables stay 0 during that ACCESS.
  - RESP gives `ls_rvalid`=1, `ls_err`=1, `ls_rdata`=0.
- **IF data:** `if_rdata` = raw `mem_r_dat`. IF never errors.
- **Withdrawn request:** a requester dropping req before gnt is legal. Only live requests are considered.

## Timing
- **Reset:** all outputs are 0, state is IDLE, pointer is IF.
- **Reset mid-operation:** asserting `rst_n` low in ACCESS or RESP aborts the access. No rvalid is produced and no BRAM write enable occurs after reset.
- **Latency:** if req is high at the edge k while the FSM is in IDLE or RESP, then:
  - gnt is high in cycle k+1, and the BRAM is driven that same cycle;
  - rvalid is high in cycle k+2.
- **Throughput:** back-to-back requests are granted every 2 cycles (RESP overlaps the next grant).
- **Pulse widths:** gnt and rvalid are never high for more than one consecutive cycle for the same requester.
- **Registering:** gnt, rvalid, rdata and err are registered outputs.

## Test plan
- Reset and idle: hold `rst_n`=0 with reqs high → all outputs 0. Release with no req → `mem_*_enb` stay 0 indefinitely.
- IF fetch: preload word 0x00000013 at 0x010, pulse `if_req` with `if_addr`=0x010 → `if_gnt` in cycle k+1, `if_rvalid` with `if_rdata`=0x00000013 in k+2.
- Conflict: `if_req` and `ls_req` both held from reset → LSU, IF, LSU, IF grants, each gnt 2 cycles apart.
- Byte store/load: store `ls_size`=00 at 0x103 with `ls_wdata`=0x000000A5 → `mem_w_enb`=4'b1000 and `mem_w_dat`=0xA5A5A5A5. Then a signed byte load at 0x103 returns 0xFFFFFFA5, and an unsigned one returns 0x000000A5.
- Half load: word 0x8001_7F02 at 0x200 → half signed at 0x202 returns 0xFFFF8001; half unsigned at 0x200 returns 0x00007F02.
- Misaligned: word store at 0x006 → `ls_gnt`, then `ls_rvalid`=1, `ls_err`=1, `ls_rdata`=0, with `mem_w_enb`=0 throughout. Also apply reset during an ACCESS store → no write and no rvalid.
